// File: rtl/ram_arbiter.sv
// Two-requester arbiter and beat sequencer for the shared 256x8 data RAM.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin ties and burst limiting on both ports.
module ram_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       we_a,
  input  logic [7:0] addr_a,
  input  logic [7:0] wdata_a,
  output logic       gnt_a,
  output logic [7:0] rdata_a,
  output logic       rvalid_a,
  input  logic       req_b,
  input  logic       we_b,
  input  logic [7:0] addr_b,
  input  logic [7:0] wdata_b,
  output logic       gnt_b,
  output logic [7:0] rdata_b,
  output logic       rvalid_b,
  output logic       ram_wr_en,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_datain,
  input  logic [7:0] ram_dataout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit LIM_A = 1'b1;
`else
  localparam bit LIM_A = 1'b0;
`endif

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       tie_a;

  // Beat count saturates at the burst limit while the other side is quiet.
  function automatic logic [3:0] cnt_inc(input logic [3:0] c);
    return (c >= BURST_MAX) ? BURST_MAX : c + 4'd1;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  // last = 1 means B took the most recent beat, so A wins the next tie.
  logic last, last_nxt;

  always_comb begin
    last_nxt = last;
    if (gnt_a)
      last_nxt = 1'b0;
    else if (gnt_b)
      last_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else
      last <= last_nxt;
  end

  assign tie_a = last;
`else
  assign tie_a = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    ram_wr_en  = 1'b0;
    ram_addr   = '0;
    ram_datain = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req_a && (!req_b || tie_a))
          state_nxt = GNT_A;
        else if (req_b)
          state_nxt = GNT_B;
      end
      GNT_A: begin
        if (req_a) begin
          gnt_a      = 1'b1;
          ram_wr_en  = we_a;
          ram_addr   = addr_a;
          ram_datain = wdata_a;
          cnt_nxt    = cnt_inc(cnt);
          if (LIM_A && req_b && (cnt_inc(cnt) == BURST_MAX)) begin
            state_nxt = GNT_B;
            cnt_nxt   = '0;
          end
        end else begin
          // Owner dropped its request: spend one bubble cycle handing over.
          cnt_nxt   = '0;
          state_nxt = req_b ? GNT_B : IDLE;
        end
      end
      GNT_B: begin
        if (req_b) begin
          gnt_b      = 1'b1;
          ram_wr_en  = we_b;
          ram_addr   = addr_b;
          ram_datain = wdata_b;
          cnt_nxt    = cnt_inc(cnt);
          if (req_a && (cnt_inc(cnt) == BURST_MAX)) begin
            state_nxt = GNT_A;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt   = '0;
          state_nxt = req_a ? GNT_A : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Read data is captured at the end of the access cycle and presented the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rvalid_a <= gnt_a & ~we_a;
      rvalid_b <= gnt_b & ~we_b;
      if (gnt_a && !we_a)
        rdata_a <= ram_dataout;
      if (gnt_b && !we_b)
        rdata_b <= ram_dataout;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed grant-trace table, reset-mid-burst sequence and random traffic
// checked against a transaction-level scoreboard with a shadow RAM.
module tb_ram_arbiter;
  localparam int MAX_BURST = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit LIM_A = 1'b1;
`else
  localparam bit LIM_A = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, we_a, req_b, we_b;
  logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic       ram_wr_en;
  logic [7:0] ram_addr, ram_datain, ram_dataout;

  ram_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_datain(ram_datain),
    .ram_dataout(ram_dataout)
  );

  always #5 clk = ~clk;

  // The RAM itself: negedge write, asynchronous read.
  logic [7:0] mem [256];
  logic       mem_clr = 1'b0;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) % 256);
  endfunction

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (ram_wr_en) begin
      mem[ram_addr] <= ram_datain;
    end
  end
  assign ram_dataout = mem[ram_addr];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         start;
  } op_t;

  typedef struct {
    string      name;
    bit         rst_first;
    int         na, ka;
    logic [7:0] aa, da;
    int         sa, la, lsa;
    int         nb, kb;
    logic [7:0] ab, db;
    int         sb;
    string      exp;
  } vec_t;

  op_t        qa[$], qb[$];
  logic [7:0] ref_mem [256];
  logic       exp_rv_a, exp_rv_b;
  logic [7:0] exp_rd_a, exp_rd_b;
  int         run_a, run_b;
  bit         yield_a, yield_b;
  bit         g_a, g_b;
  int         cyc;
  string      trace;
  int         n_chk = 0;
  int         n_fail = 0;
  vec_t       vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: grant trace got \"%s\", expected \"%s\"", nm, act, exp);
    end
  endtask

  task automatic ctl_model_reset();
    exp_rv_a = 1'b0; exp_rv_b = 1'b0;
    exp_rd_a = 8'h00; exp_rd_b = 8'h00;
    run_a = 0; run_b = 0;
    yield_a = 1'b0; yield_b = 1'b0;
    g_a = 1'b0; g_b = 1'b0;
  endtask

  task automatic drive();
    if (qa.size() > 0 && cyc >= qa[0].start) begin
      req_a = 1'b1; we_a = qa[0].we; addr_a = qa[0].addr; wdata_a = qa[0].wdata;
    end else begin
      req_a = 1'b0; we_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
    end
    if (qb.size() > 0 && cyc >= qb[0].start) begin
      req_b = 1'b1; we_b = qb[0].we; addr_b = qb[0].addr; wdata_b = qb[0].wdata;
    end else begin
      req_b = 1'b0; we_b = 1'b0; addr_b = 8'h00; wdata_b = 8'h00;
    end
  endtask

  task automatic beat(input string who, input op_t op, output logic rv, inout logic [7:0] rd);
    chk({who, "_ram_addr"}, 32'(ram_addr), 32'(op.addr));
    chk({who, "_ram_wr_en"}, 32'(ram_wr_en), 32'(op.we));
    chk({who, "_ram_datain"}, 32'(ram_datain), 32'(op.wdata));
    if (op.we) begin
      ref_mem[op.addr] = op.wdata;
      rv = 1'b0;
    end else begin
      rv = 1'b1;
      rd = ref_mem[op.addr];
    end
  endtask

  task automatic monitor();
    logic nrv_a, nrv_b;
    nrv_a = 1'b0;
    nrv_b = 1'b0;
    chk("gnt_exclusive", 32'(g_a & g_b), 32'd0);
    chk("gnt_a_needs_req", 32'(g_a & ~req_a), 32'd0);
    chk("gnt_b_needs_req", 32'(g_b & ~req_b), 32'd0);
    chk("rvalid_a", 32'(rvalid_a), 32'(exp_rv_a));
    chk("rvalid_b", 32'(rvalid_b), 32'(exp_rv_b));
    chk("rdata_a", 32'(rdata_a), 32'(exp_rd_a));
    chk("rdata_b", 32'(rdata_b), 32'(exp_rd_b));
    if (yield_a) begin
      chk("burst_a_release", 32'(g_a), 32'd0);
      chk("burst_a_handover", 32'(g_b), 32'd1);
    end
    if (yield_b) begin
      chk("burst_b_release", 32'(g_b), 32'd0);
      chk("burst_b_handover", 32'(g_a), 32'd1);
    end
    if (g_a && qa.size() > 0) beat("a", qa[0], nrv_a, exp_rd_a);
    if (g_b && qb.size() > 0) beat("b", qb[0], nrv_b, exp_rd_b);
    if (!g_a && !g_b) begin
      chk("idle_wr_en", 32'(ram_wr_en), 32'd0);
      chk("idle_addr", 32'(ram_addr), 32'd0);
      chk("idle_datain", 32'(ram_datain), 32'd0);
    end
    exp_rv_a = nrv_a;
    exp_rv_b = nrv_b;
    run_a = g_a ? run_a + 1 : 0;
    run_b = g_b ? run_b + 1 : 0;
    yield_a = LIM_A && g_a && (run_a >= MAX_BURST) && req_b;
    yield_b = g_b && (run_b >= MAX_BURST) && req_a;
  endtask

  task automatic run_cycle();
    string ch;
    @(posedge clk);
    #1;
    if (g_a && qa.size() > 0) qa.delete(0);
    if (g_b && qb.size() > 0) qb.delete(0);
    cyc++;
    drive();
    #2;
    g_a = gnt_a;
    g_b = gnt_b;
    ch = (g_a && g_b) ? "X" : g_a ? "A" : g_b ? "B" : ".";
    trace = {trace, ch};
    monitor();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_clr = 1'b1;
    qa.delete();
    qb.delete();
    cyc = 0;
    drive();
    @(posedge clk);
    #1;
    mem_clr = 1'b0;
    #2;
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_datain", 32'(ram_datain), 32'd0);
    chk("rst_rvalid", 32'({rvalid_a, rvalid_b}), 32'd0);
    chk("rst_rdata", 32'({rdata_a, rdata_b}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    ctl_model_reset();
  endtask

  task automatic fill(input bit is_b, input int n, input int kind, input logic [7:0] base_a,
                      input logic [7:0] base_d, input int start, input int late_idx,
                      input int late_start);
    op_t op;
    for (int i = 0; i < n; i++) begin
      op.we    = (kind == 1) || (kind == 2 && i == 0);
      op.addr  = (kind == 2) ? base_a : base_a + 8'(i);
      op.wdata = base_d + 8'(i);
      op.start = (late_idx >= 0 && i >= late_idx) ? late_start : start;
      if (is_b) qb.push_back(op);
      else qa.push_back(op);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_both, exp_tie;
    int    beats;
    op_t   op;
    int    t;
    rst = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
    req_b = 1'b0; we_b = 1'b0; addr_b = 8'h00; wdata_b = 8'h00;
    trace = "";
    ctl_model_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_both = ".AAAABBBBAA.BB..";
    exp_tie  = ".A...B.A..";
`else
    exp_both = ".AAAAAA.BBBBBB..";
    exp_tie  = ".A...A.B..";
`endif
    // name, rst_first, na, ka, aa, da, sa, la, lsa, nb, kb, ab, db, sb, expected grant trace
    // kind: 0 all reads, 1 all writes, 2 write then reads of the same address
    vecs[0] = '{"a_wr_rd", 1'b1, 2, 2, 8'h10, 8'h5A, 0, -1, 0, 0, 0, 8'h00, 8'h00, 0, ".AA.."};
    vecs[1] = '{"b_ff_rw", 1'b0, 0, 0, 8'h00, 8'h00, 0, -1, 0, 2, 2, 8'hFF, 8'hFF, 0, ".BB.."};
    vecs[2] = '{"both_6rd", 1'b1, 6, 0, 8'h40, 8'h07, 0, -1, 0, 6, 0, 8'h80, 8'h09, 0, exp_both};
    vecs[3] = '{"b8wr_a_at2", 1'b1, 1, 1, 8'h30, 8'hC3, 3, -1, 0, 8, 1, 8'h90, 8'h11, 0,
                ".BBBBA.BBBB.."};
    vecs[4] = '{"tie_after_a", 1'b1, 2, 0, 8'h50, 8'h02, 0, 1, 5, 1, 0, 8'hA0, 8'h04, 5, exp_tie};

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].rst_first) do_reset();
      cyc = 0;
      trace = "";
      fill(1'b0, vecs[v].na, vecs[v].ka, vecs[v].aa, vecs[v].da, vecs[v].sa, vecs[v].la,
           vecs[v].lsa);
      fill(1'b1, vecs[v].nb, vecs[v].kb, vecs[v].ab, vecs[v].db, vecs[v].sb, -1, 0);
      for (int c = 0; c < vecs[v].exp.len(); c++) run_cycle();
      chk_s(vecs[v].name, trace, vecs[v].exp);
      chk({vecs[v].name, "_drained"}, 32'(qa.size() + qb.size()), 32'd0);
      if (v == 1) chk("b_ff_rdata_b", 32'(rdata_b), 32'hFF);
    end

    // Reset lands during A's third write beat.
    do_reset();
    cyc = 0;
    trace = "";
    fill(1'b0, 5, 1, 8'h20, 8'h61, 0, -1, 0);
    beats = 0;
    for (int c = 0; c < 10 && beats < 3; c++) begin
      run_cycle();
      if (g_a) beats++;
    end
    chk("rst_mid_third_beat", 32'(beats), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_a = 1'b1; we_a = 1'b1; addr_a = 8'h23; wdata_a = 8'h64;
    #2;
    chk("rst_mid_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_mid_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_mid_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_mid_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_mid_rvalid_a", 32'(rvalid_a), 32'd0);
    qa.delete();
    ctl_model_reset();
    for (int c = 0; c < 3; c++) run_cycle();
    for (int i = 0; i < 5; i++) chk("rst_mid_ram", 32'(mem[8'h20 + 8'(i)]), 32'(ref_mem[8'h20 + 8'(i)]));

    // Random traffic from both ports over a small address window.
    do_reset();
    cyc = 0;
    trace = "";
    t = 0;
    for (int i = 0; i < 40; i++) begin
      t += $urandom_range(0, 3);
      op.we = 1'($urandom_range(0, 1));
      op.addr = 8'($urandom_range(0, 7));
      op.wdata = 8'($urandom);
      op.start = t;
      qa.push_back(op);
    end
    t = 0;
    for (int i = 0; i < 40; i++) begin
      t += $urandom_range(0, 3);
      op.we = 1'($urandom_range(0, 1));
      op.addr = 8'($urandom_range(0, 7));
      op.wdata = 8'($urandom);
      op.start = t;
      qb.push_back(op);
    end
    for (int c = 0; c < 1000 && (qa.size() > 0 || qb.size() > 0); c++) run_cycle();
    chk("rand_drained", 32'(qa.size() + qb.size()), 32'd0);
    for (int c = 0; c < 3; c++) run_cycle();
    for (int i = 0; i < 8; i++) chk("rand_ram", 32'(mem[i]), 32'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
